// File: rtl/opl_pg_multislot.sv
`default_nettype none
// ============================================================================
// Module   : opl_pg_multislot
// Brief    : Time-multiplexed per-slot phase generator. A 3-stage pipeline
//            turns F-number/block/MUL/vibrato into a phase increment and
//            accumulates it into a counter-addressed slot store. The block
//            keeps its own slot counter, re-synced by i_SLOT_START.
// Revision : 1.0 - initial release
// ============================================================================
module opl_pg_multislot #(
    parameter int NUM_SLOTS = 18,
    parameter int FNUM_W    = 9,
    parameter int PHASE_W   = 19,
    parameter int OUT_W     = 10
) (
    input  logic                         i_EMUCLK,
    input  logic                         i_IC,
    input  logic                         i_CEN_n,
    input  logic                         i_SLOT_START,
    input  logic [FNUM_W-1:0]            i_FNUM,
    input  logic [2:0]                   i_BLOCK,
    input  logic [3:0]                   i_MUL,
    input  logic                         i_PM,
    input  logic [2:0]                   i_PMVAL,
    input  logic                         i_PHASE_RST,
    input  logic                         i_FREEZE,
    output logic [$clog2(NUM_SLOTS)-1:0] o_SLOT,
    output logic [OUT_W-1:0]             o_OP_PHASE,
    output logic                         o_PHASE_VALID,
    output logic                         o_WRAP
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    // Signed width of 2*FNUM + pm
    localparam int M_W    = FNUM_W + 2;
    // Width of (m << 7) >> 1 for a non-negative m of FNUM_W+1 bits
    localparam int D_W    = FNUM_W + 7;
    // Product must hold d*30 and also reach bit PHASE_W for the >>1 slice
    localparam int PR_W   = (D_W + 5 > PHASE_W + 1) ? (D_W + 5) : (PHASE_W + 1);
    localparam logic [SLOT_W-1:0] c_LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    logic                    w_en;
    assign w_en = ~i_CEN_n;

    // ---------------- slot counter ----------------
    logic [SLOT_W-1:0] cnt_q, cnt_d, w_slot;

    // Frame start forces slot 0; the counter then continues from there
    always_comb begin
        w_slot = i_SLOT_START ? '0 : cnt_q;
        cnt_d  = (w_slot == c_LAST_SLOT) ? '0 : w_slot + SLOT_W'(1);
    end

    // ---------------- stage 1: vibrato-adjusted, block-shifted F-number ----
    logic [2:0]            w_t;
    logic [2:0]            w_pm_mag;
    logic signed [M_W-1:0] w_pm;
    logic signed [M_W-1:0] w_m;
    logic [M_W-2:0]        w_m_pos;
    logic [D_W:0]          w_shl;
    logic [D_W-1:0]        w_d;

    // Vibrato offset from the top F-number bits, then clamp and octave shift
    always_comb begin
        w_t      = i_FNUM[FNUM_W-1 -: 3];
        w_pm_mag = 3'd0;
        if (i_PM && (i_PMVAL[1:0] != 2'd0)) begin
            w_pm_mag = (i_PMVAL[1:0] == 2'd2) ? w_t : (w_t >> 1);
        end
        w_pm = {{(M_W-3){1'b0}}, w_pm_mag};
        if (i_PM && i_PMVAL[2]) begin
            w_pm = -w_pm;
        end
        // Signed sum wraps in M_W bits; anything that reads negative clamps to 0
        w_m     = $signed({1'b0, i_FNUM, 1'b0}) + w_pm;
        w_m_pos = w_m[M_W-1] ? '0 : w_m[M_W-2:0];
        w_shl   = {7'd0, w_m_pos} << i_BLOCK;
        w_d     = w_shl[D_W:1];
    end

    logic                    s1_valid_q;
    logic [SLOT_W-1:0]       s1_slot_q;
    logic [D_W-1:0]          s1_d_q;
    logic [3:0]              s1_mul_q;
    logic                    s1_rst_q, s1_frz_q;

    // ---------------- stage 2: MUL factor ----------------
    logic [4:0]              w_f;
    logic [PR_W-1:0]         w_prod;
    logic [PHASE_W-1:0]      w_delta;

    // OPL multiplier table is stored doubled so x0.5 stays an integer
    always_comb begin
        case (s1_mul_q)
            4'd0:    w_f = 5'd1;
            4'd1:    w_f = 5'd2;
            4'd2:    w_f = 5'd4;
            4'd3:    w_f = 5'd6;
            4'd4:    w_f = 5'd8;
            4'd5:    w_f = 5'd10;
            4'd6:    w_f = 5'd12;
            4'd7:    w_f = 5'd14;
            4'd8:    w_f = 5'd16;
            4'd9:    w_f = 5'd18;
            4'd10:   w_f = 5'd20;
            4'd11:   w_f = 5'd20;
            4'd12:   w_f = 5'd24;
            4'd13:   w_f = 5'd24;
            default: w_f = 5'd30;
        endcase
        w_prod  = PR_W'(s1_d_q) * PR_W'(w_f);
        w_delta = w_prod[PHASE_W:1];
    end

    logic                    s2_valid_q;
    logic [SLOT_W-1:0]       s2_slot_q;
    logic [PHASE_W-1:0]      s2_delta_q;
    logic                    s2_rst_q, s2_frz_q;

    // ---------------- stage 3: accumulate into slot store ----------------
    logic [PHASE_W-1:0]      store_q [NUM_SLOTS];
    logic [PHASE_W-1:0]      w_p;
    logic [PHASE_W:0]        w_sum;
    logic [PHASE_W-1:0]      w_next;
    logic                    w_wrap;

    // Key-on reset beats freeze; wrap is only reported for a real accumulate
    always_comb begin
        w_p   = store_q[s2_slot_q];
        w_sum = {1'b0, w_p} + {1'b0, s2_delta_q};
        if (s2_rst_q) begin
            w_next = s2_delta_q;
            w_wrap = 1'b0;
        end else if (s2_frz_q) begin
            w_next = w_p;
            w_wrap = 1'b0;
        end else begin
            w_next = w_sum[PHASE_W-1:0];
            w_wrap = w_sum[PHASE_W];
        end
    end

    // Pipeline, slot counter, store and output registers
    always_ff @(posedge i_EMUCLK) begin
        if (i_IC) begin
            cnt_q         <= '0;
            s1_valid_q    <= 1'b0;
            s1_slot_q     <= '0;
            s1_d_q        <= '0;
            s1_mul_q      <= '0;
            s1_rst_q      <= 1'b0;
            s1_frz_q      <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_slot_q     <= '0;
            s2_delta_q    <= '0;
            s2_rst_q      <= 1'b0;
            s2_frz_q      <= 1'b0;
            o_SLOT        <= '0;
            o_OP_PHASE    <= '0;
            o_PHASE_VALID <= 1'b0;
            o_WRAP        <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                store_q[i] <= '0;
            end
        end else if (w_en) begin
            cnt_q         <= cnt_d;
            s1_valid_q    <= 1'b1;
            s1_slot_q     <= w_slot;
            s1_d_q        <= w_d;
            s1_mul_q      <= i_MUL;
            s1_rst_q      <= i_PHASE_RST;
            s1_frz_q      <= i_FREEZE;
            s2_valid_q    <= s1_valid_q;
            s2_slot_q     <= s1_slot_q;
            s2_delta_q    <= w_delta;
            s2_rst_q      <= s1_rst_q;
            s2_frz_q      <= s1_frz_q;
            o_PHASE_VALID <= s2_valid_q;
            if (s2_valid_q) begin
                store_q[s2_slot_q] <= w_next;
                o_SLOT             <= s2_slot_q;
                o_OP_PHASE         <= w_next[PHASE_W-1 -: OUT_W];
                o_WRAP             <= w_wrap;
            end else begin
                o_SLOT             <= '0;
                o_OP_PHASE         <= '0;
                o_WRAP             <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_opl_pg_multislot.sv
`default_nettype none
// ============================================================================
// Module   : tb_opl_pg_multislot
// Brief    : Self-checking bench for opl_pg_multislot with a queue-based
//            reference model of the phase pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opl_pg_multislot;

    localparam int NS = 18;
    localparam int FW = 9;
    localparam int PW = 19;
    localparam int OW = 10;
    localparam int SW = $clog2(NS);
    localparam longint MOD = longint'(1) << PW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          ic, cen_n, sstart, pm, prst, frz;
    logic [FW-1:0] fnum;
    logic [2:0]    blk, pmval;
    logic [3:0]    mul;
    logic [SW-1:0] o_slot;
    logic [OW-1:0] o_ph;
    logic          o_v, o_w;

    opl_pg_multislot #(.NUM_SLOTS(NS), .FNUM_W(FW), .PHASE_W(PW), .OUT_W(OW)) dut (
        .i_EMUCLK(clk), .i_IC(ic), .i_CEN_n(cen_n), .i_SLOT_START(sstart),
        .i_FNUM(fnum), .i_BLOCK(blk), .i_MUL(mul), .i_PM(pm), .i_PMVAL(pmval),
        .i_PHASE_RST(prst), .i_FREEZE(frz),
        .o_SLOT(o_slot), .o_OP_PHASE(o_ph), .o_PHASE_VALID(o_v), .o_WRAP(o_w)
    );

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int     slot;
        longint delta;
        bit     rst;
        bit     frz;
    } pend_t;

    pend_t  q[$];
    longint mstore[NS];
    int     m_cnt;
    bit     exp_known, exp_valid, exp_wrap;
    int     exp_slot;
    longint exp_phase;

    int c_fnum[NS], c_blk[NS], c_mul[NS], c_pmval[NS];
    bit c_pm[NS], c_frz[NS];
    int obs_phase[NS];
    bit obs_wrap[NS];

    function automatic longint mul_factor(int mu);
        case (mu)
            0: return 1;   1: return 2;   2: return 4;   3: return 6;
            4: return 8;   5: return 10;  6: return 12;  7: return 14;
            8: return 16;  9: return 18;  10: return 20; 11: return 20;
            12: return 24; 13: return 24; default: return 30;
        endcase
    endfunction

    // Phase increment straight from the arithmetic rules
    function automatic longint ref_delta(int f, int b, int mu, bit p, int pv);
        longint pmv = 0;
        longint m, d;
        if (p && (pv % 4) != 0) begin
            longint t = longint'(f >> (FW - 3));
            pmv = ((pv % 4) == 2) ? t : t / 2;
            if (pv >= 4) pmv = -pmv;
        end
        m = 2 * longint'(f) + pmv;
        // Out of the signed FW+2-bit range reads as negative -> clamp
        if (m < 0 || m >= (longint'(1) << (FW + 1))) m = 0;
        d = (m << b) / 2;
        return ((d * mul_factor(mu)) / 2) % MOD;
    endfunction

    function automatic longint cfg_delta(int s);
        return ref_delta(c_fnum[s], c_blk[s], c_mul[s], c_pm[s], c_pmval[s]);
    endfunction

    // One clock: update model for this edge, then compare after the edge
    task automatic tick();
        if (ic) begin
            q.delete();
            foreach (mstore[i]) mstore[i] = 0;
            m_cnt = 0; exp_known = 1; exp_valid = 0;
            exp_slot = 0; exp_phase = 0; exp_wrap = 0;
        end else if (!cen_n) begin
            pend_t cur;
            cur.slot  = sstart ? 0 : m_cnt;
            m_cnt     = (cur.slot + 1) % NS;
            cur.delta = ref_delta(int'(fnum), int'(blk), int'(mul), pm, int'(pmval));
            cur.rst   = prst;
            cur.frz   = frz;
            q.push_back(cur);
            if (q.size() > 2) begin
                pend_t  p = q.pop_front();
                longint nxt, sum;
                bit     w;
                sum = mstore[p.slot] + p.delta;
                if (p.rst)      begin nxt = p.delta;         w = 0; end
                else if (p.frz) begin nxt = mstore[p.slot];  w = 0; end
                else            begin nxt = sum % MOD;       w = (sum >= MOD); end
                mstore[p.slot] = nxt;
                exp_known = 1; exp_valid = 1; exp_slot = p.slot;
                exp_phase = nxt >> (PW - OW); exp_wrap = w;
            end else begin
                exp_known = 0; exp_valid = 0;
            end
        end
        @(posedge clk); #1;
        nchk++;
        if (o_v !== exp_valid) begin
            nerr++;
            $display("FAIL valid @%0t: got %0d want %0d", $time, o_v, exp_valid);
        end
        if (exp_known) begin
            nchk++;
            if (o_slot !== SW'(exp_slot) || o_ph !== OW'(exp_phase) || o_w !== exp_wrap) begin
                nerr++;
                $display("FAIL out @%0t: got slot %0d ph %0d wrap %0d want slot %0d ph %0d wrap %0d",
                         $time, o_slot, o_ph, o_w, exp_slot, exp_phase, exp_wrap);
            end
        end
        if (o_v === 1'b1 && int'(o_slot) < NS) begin
            obs_phase[o_slot] = int'(o_ph);
            obs_wrap[o_slot]  = o_w;
        end
    endtask

    task automatic rand_inputs();
        fnum  = FW'($urandom);
        blk   = 3'($urandom);
        mul   = 4'($urandom);
        pm    = 1'($urandom);
        pmval = 3'($urandom);
        prst  = 1'($urandom);
        frz   = 1'($urandom);
    endtask

    task automatic drive_slot(int s);
        fnum  = FW'(c_fnum[s]);
        blk   = 3'(c_blk[s]);
        mul   = 4'(c_mul[s]);
        pm    = c_pm[s];
        pmval = 3'(c_pmval[s]);
        prst  = 1'b0;
        frz   = c_frz[s];
    endtask

    task automatic rand_cfg();
        for (int s = 0; s < NS; s++) begin
            c_fnum[s]  = int'($urandom_range(0, (1 << FW) - 1));
            c_blk[s]   = int'($urandom_range(0, 7));
            c_mul[s]   = int'($urandom_range(0, 15));
            c_pm[s]    = 1'($urandom);
            c_pmval[s] = int'($urandom_range(0, 7));
            c_frz[s]   = 1'b0;
        end
    endtask

    // n enables, each preceded by 0..gap_max idle cycles with junk inputs
    task automatic run_enables(int n, int gap_max, bit rnd_flags);
        for (int i = 0; i < n; i++) begin
            int gaps = int'($urandom_range(0, gap_max));
            for (int g = 0; g < gaps; g++) begin
                cen_n = 1'b1; rand_inputs(); tick();
            end
            cen_n  = 1'b0;
            sstart = (m_cnt == 0);
            drive_slot(m_cnt);
            if (rnd_flags) begin
                prst = ($urandom_range(0, 7) == 0);
                frz  = frz | ($urandom_range(0, 7) == 0);
            end
            tick();
        end
        cen_n = 1'b1; sstart = 1'b0; prst = 1'b0; frz = 1'b0;
    endtask

    task automatic do_reset();
        ic = 1'b1; cen_n = 1'b0; tick(); tick();
        ic = 1'b0; cen_n = 1'b1; sstart = 1'b0;
        foreach (obs_phase[i]) begin obs_phase[i] = -1; obs_wrap[i] = 0; end
    endtask

    task automatic test_reset();
        ic = 1'b1; cen_n = 1'b1; rand_inputs(); tick();
        cen_n = 1'b0; tick(); tick();
        nchk++;
        if (o_slot !== '0 || o_ph !== '0 || o_v !== 1'b0 || o_w !== 1'b0) begin
            nerr++;
            $display("FAIL reset_outputs: got %0d/%0d/%0d/%0d want 0/0/0/0", o_slot, o_ph, o_v, o_w);
        end
        ic = 1'b0; cen_n = 1'b1; sstart = 1'b0; prst = 1'b0; frz = 1'b0;
        tick(); tick();
    endtask

    task automatic test_basic();
        do_reset(); rand_cfg();
        c_fnum[0] = 256; c_blk[0] = 4; c_mul[0] = 1; c_pm[0] = 0;
        run_enables(NS, 0, 0);
        nchk++; if (obs_phase[0] != 8) begin nerr++; $display("FAIL basic_upd1: got %0d want 8", obs_phase[0]); end
        run_enables(NS, 0, 0);
        nchk++; if (obs_phase[0] != 16) begin nerr++; $display("FAIL basic_upd2: got %0d want 16", obs_phase[0]); end
        run_enables(126 * NS, 0, 0);
        nchk++;
        if (obs_phase[0] != 0 || obs_wrap[0] != 1) begin
            nerr++; $display("FAIL basic_wrap128: got ph %0d wrap %0d want 0 1", obs_phase[0], obs_wrap[0]);
        end
    endtask

    task automatic test_mul();
        do_reset(); rand_cfg();
        c_fnum[0] = 256; c_blk[0] = 4; c_mul[0] = 0; c_pm[0] = 0;
        run_enables(NS, 0, 0);
        nchk++; if (obs_phase[0] != 4) begin nerr++; $display("FAIL mul0: got %0d want 4", obs_phase[0]); end
        do_reset();
        c_mul[0] = 15;
        run_enables(NS, 0, 0);
        nchk++; if (obs_phase[0] != 120) begin nerr++; $display("FAIL mul15: got %0d want 120", obs_phase[0]); end
    endtask

    // 512 updates of delta leave exactly delta in the top OW bits
    task automatic test_vibrato();
        do_reset(); rand_cfg();
        for (int s = 0; s < 4; s++) begin c_fnum[s] = 448; c_blk[s] = 0; c_mul[s] = 1; c_pm[s] = 1; end
        c_pmval[0] = 2; c_pmval[1] = 6; c_pmval[2] = 1; c_pm[3] = 0; c_pmval[3] = 2;
        run_enables(512 * NS, 0, 0);
        nchk++; if (obs_phase[0] != 451) begin nerr++; $display("FAIL pm_2: got %0d want 451", obs_phase[0]); end
        nchk++; if (obs_phase[1] != 444) begin nerr++; $display("FAIL pm_6: got %0d want 444", obs_phase[1]); end
        nchk++; if (obs_phase[2] != 449) begin nerr++; $display("FAIL pm_1: got %0d want 449", obs_phase[2]); end
        nchk++; if (obs_phase[3] != 448) begin nerr++; $display("FAIL pm_off: got %0d want 448", obs_phase[3]); end
    endtask

    task automatic test_rst_freeze();
        int held;
        int want;
        do_reset(); rand_cfg();
        c_fnum[5] = 300; c_blk[5] = 5; c_mul[5] = 1; c_pm[5] = 0;
        run_enables(3 * NS, 0, 0);
        run_enables(5, 0, 0);
        cen_n = 1'b0; sstart = 1'b0; drive_slot(5); prst = 1'b1; frz = 1'b1; tick();
        prst = 1'b0; frz = 1'b0;
        run_enables(2, 0, 0);
        want = int'(cfg_delta(5) >> (PW - OW));
        nchk++;
        if (obs_phase[5] != want || obs_wrap[5] != 0) begin
            nerr++; $display("FAIL rst_beats_freeze: got ph %0d wrap %0d want %0d 0", obs_phase[5], obs_wrap[5], want);
        end
        run_enables(NS - 8, 0, 0);
        run_enables(NS, 0, 0);
        held = obs_phase[5];
        c_frz[5] = 1'b1;
        run_enables(3 * NS, 1, 0);
        c_frz[5] = 1'b0;
        nchk++;
        if (obs_phase[5] != held || held == 0) begin
            nerr++; $display("FAIL freeze_hold: got %0d want %0d (nonzero)", obs_phase[5], held);
        end
    endtask

    task automatic test_irregular();
        do_reset(); rand_cfg();
        run_enables(3 * NS, 5, 1);
        run_enables(7, 3, 0);
        cen_n = 1'b0; sstart = 1'b1; drive_slot(0); tick();
        sstart = 1'b0;
        run_enables(2, 4, 0);
        nchk++;
        if (o_slot !== '0 || o_v !== 1'b1) begin
            nerr++; $display("FAIL slot_start_resync: got slot %0d valid %0d want 0 1", o_slot, o_v);
        end
        run_enables(2 * NS, 5, 0);
    endtask

    task automatic test_reset_mid();
        do_reset(); rand_cfg();
        run_enables(2 * NS + 7, 1, 0);
        ic = 1'b1; cen_n = 1'b0; rand_inputs(); tick();
        ic = 1'b0; cen_n = 1'b1; prst = 1'b0; frz = 1'b0;
        nchk++;
        if (o_slot !== '0 || o_ph !== '0 || o_v !== 1'b0 || o_w !== 1'b0) begin
            nerr++; $display("FAIL midreset_zero: got %0d/%0d/%0d/%0d want 0/0/0/0", o_slot, o_ph, o_v, o_w);
        end
        foreach (obs_phase[i]) obs_phase[i] = -1;
        run_enables(NS, 2, 0);
        for (int s = 0; s < NS - 2; s++) begin
            int want = int'(cfg_delta(s) >> (PW - OW));
            nchk++;
            if (obs_phase[s] != want) begin
                nerr++; $display("FAIL midreset_restart slot %0d: got %0d want %0d", s, obs_phase[s], want);
            end
        end
    endtask

    task automatic test_random();
        do_reset(); rand_cfg();
        run_enables(10 * NS, 2, 1);
    endtask

    initial begin
        ic = 1'b1; cen_n = 1'b1; sstart = 1'b0;
        fnum = '0; blk = '0; mul = '0; pm = 1'b0; pmval = '0; prst = 1'b0; frz = 1'b0;
        m_cnt = 0; exp_known = 0; exp_valid = 0; exp_slot = 0; exp_phase = 0; exp_wrap = 0;
        test_reset();
        test_basic();
        test_mul();
        test_vibrato();
        test_rst_freeze();
        test_irregular();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/opl_pg_multislot.md
Name: opl_pg_multislot

Overview:
- Parametrised per-slot phase generator, next generation of the OPLL phase generator.
- Slot count, F-number width, accumulator width and output width are set by parameters.
- Phase state is held in a counter-addressed slot store instead of a fixed-length delay line. The block keeps its own slot counter and re-syncs it to an external frame start.
- Adds an OPL-style MUL lookup, a per-slot wrap flag, a freeze mode, and an output-valid/slot tag for downstream operators.

Parameters:
NUM_SLOTS, 18, number of time-multiplexed slots (2..64)
FNUM_W, 9, F-number width (9 = OPLL, 10 = OPL2-style)
PHASE_W, 19, phase accumulator width
OUT_W, 10, operator phase output width (MSBs of accumulator), OUT_W <= PHASE_W

Ports:
i_EMUCLK  in  1  emulator master clock
i_IC  in  1  synchronous active-high reset
i_CEN_n  in  1  active-low slot-advance enable; all state changes only when low (reset excepted)
i_SLOT_START  in  1  marks the current enable cycle as slot 0
i_FNUM  in  FNUM_W  F-number of current slot
i_BLOCK  in  3  octave of current slot
i_MUL  in  4  multiplier code of current slot
i_PM  in  1  vibrato enable of current slot
i_PMVAL  in  3  vibrato step: [2] sign (1 = negative), [1:0] depth phase
i_PHASE_RST  in  1  key-on phase reset for current slot
i_FREEZE  in  1  test: hold current slot's accumulator
o_SLOT  out  clog2(NUM_SLOTS)  slot index of presented output
o_OP_PHASE  out  OUT_W  phase of o_SLOT
o_PHASE_VALID  out  1  output registers hold a real slot result
o_WRAP  out  1  accumulator of o_SLOT overflowed on this update

Behaviour:

Reset (i_IC high at a clock edge):
- Slot counter = 0; all NUM_SLOTS store entries = 0.
- Pipeline valid bits = 0; o_SLOT = 0, o_OP_PHASE = 0, o_PHASE_VALID = 0, o_WRAP = 0.
- Reset wins over i_CEN_n.
- Mid-operation reset discards in-flight slots; nothing is written back.

Slot counter:
- Advances on each enable cycle, wrapping NUM_SLOTS-1 -> 0.
- i_SLOT_START high: inputs of that cycle belong to slot 0, and the counter becomes 1 afterward.

Pipeline: three registered stages, each advanced only on an enable cycle.

Stage 1 (inputs sampled at enable n):
- pm = 0 when i_PM = 0 or PMVAL[1:0] = 0.
- Otherwise t = FNUM[FNUM_W-1 -: 3]; pm = t>>1 for PMVAL[1:0] = 1 or 3, pm = t for PMVAL[1:0] = 2.
- Negate pm when i_PM & PMVAL[2].
- m = 2*FNUM + pm, computed signed in FNUM_W+2 bits; a negative m clamps to 0.
- d = (m << BLOCK) >> 1.
- Slot, PHASE_RST and FREEZE travel with the data.

Stage 2 (enable n+1):
- f = {1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30}[MUL].
- delta = (d*f) >> 1, truncated to PHASE_W bits.

Stage 3 (enable n+2):
- p = store[slot].
- Next value:
  - PHASE_RST = 1: delta. Reset wins over FREEZE.
  - else FREEZE = 1: p.
  - else (p + delta) mod 2^PHASE_W.
- Write next to store[slot].
- o_OP_PHASE = next[PHASE_W-1 -: OUT_W]; o_SLOT = slot.
- o_WRAP = carry out of p + delta; 0 when PHASE_RST or FREEZE.
- o_PHASE_VALID = stage-3 valid.

Latency and timing:
- Input at enable n appears on the outputs after the edge of enable n+2.
- Outputs hold between enables.
- o_PHASE_VALID is low for the first two enables after reset, then high every enable.
- Store read and write for a slot are NUM_SLOTS enables apart, so no forwarding is needed.
- Unused MSBs from the shift or multiply are discarded; no saturation.

Test Plan:
1. Reset, then FNUM=256, BLOCK=4, MUL=1, PM=0 on slot 0, NUM_SLOTS=18 -> delta 4096. o_SLOT=0 output shows o_OP_PHASE=8 after update 1 and 16 after update 2. After update 128 it shows o_OP_PHASE=0 with o_WRAP=1 for that slot only.
2. Same setup with MUL=0 -> delta 2048, o_OP_PHASE=4 after first update. MUL=15 -> delta 61440, o_OP_PHASE=120.
3. FNUM=448, BLOCK=0, MUL=1, PM=1 -> PMVAL=2 gives delta 451; PMVAL=6 gives 444; PMVAL=1 gives 449; PM=0 gives 448.
4. Accumulate slot 5 to nonzero, assert i_PHASE_RST and i_FREEZE together for one slot-5 pass -> stored phase = delta, o_WRAP=0. FREEZE alone -> o_OP_PHASE unchanged over 3 frames.
5. Toggle i_CEN_n irregularly (gaps of 0-5 cycles) -> results identical to continuous enables. Pulse i_SLOT_START mid-frame -> o_SLOT=0 appears two enables later and the sequence restarts.
6. Assert i_IC for one cycle mid-frame with phases nonzero -> next cycle all outputs 0. First valid after two enables; every slot restarts from 0 + delta.
